// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Elaboration-time helpers for the parametrised sequence detector.
// Revision : 1.0
// ============================================================================
package seq_det_pkg;

  localparam int MAX_PAT_W = 16;
  localparam int MAX_SW    = $clog2(MAX_PAT_W + 1);

  typedef enum logic {
    OUT_MEALY = 1'b0,
    OUT_MOORE = 1'b1
  } out_style_e;

  function automatic int state_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Bit i in arrival order (0 = first received, i.e. the pattern MSB).
  function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pattern,
                                   input int width, input int i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < MAX_PAT_W; k++) begin
      if (k == width - 1 - i) b = pattern[k];
    end
    return b;
  endfunction

  function automatic int next_prefix(input logic [MAX_PAT_W-1:0] pattern,
                                     input int width, input int s,
                                     input logic x);
    int   best;
    int   idx;
    logic ok;
    logic wb;
    best = 0;
    for (int k = 1; k <= MAX_PAT_W; k++) begin
      if (k <= s + 1 && k <= width) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PAT_W; i++) begin
          if (i < k) begin
            idx = s + 1 - k + i;
            wb  = (idx == s) ? x : pat_bit(pattern, width, idx);
            if (wb != pat_bit(pattern, width, i)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  function automatic int border_len(input logic [MAX_PAT_W-1:0] pattern,
                                    input int width);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < MAX_PAT_W; k++) begin
      if (k < width) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PAT_W; i++) begin
          if (i < k && pat_bit(pattern, width, i) != pat_bit(pattern, width, width - k + i))
            ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Brief    : Serial pattern detector, Moore/Mealy and overlap selectable.
//            Define SEQ_DET_CNT_EN to add the saturating match_cnt output.
// Revision : 1.0
// ============================================================================
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               MOORE   = 1,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          x,
  output logic                          z,
  output logic [state_width(PAT_W)-1:0] state
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0]              match_cnt
`endif
);

  localparam int                     SW      = state_width(PAT_W);
  localparam int                     NTAB    = 2 ** SW;
  localparam logic [MAX_PAT_W-1:0]   PAT_EXT = MAX_PAT_W'(PATTERN);
  localparam int                     RESTART = (OVERLAP != 0) ? border_len(PAT_EXT, PAT_W) : 0;
  localparam out_style_e             STYLE   = (MOORE != 0) ? OUT_MOORE : OUT_MEALY;
  localparam logic [SW-1:0]          S_TERM  = SW'(PAT_W);
  localparam logic [SW-1:0]          S_LAST  = SW'(PAT_W - 1);

  logic [SW-1:0] nxt0_tab [NTAB];
  logic [SW-1:0] nxt1_tab [NTAB];
  logic [SW-1:0] state_nxt;

  generate
    if (PAT_W < 2 || PAT_W > MAX_PAT_W || CNT_W < 1) begin : g_param_check
      $error("seq_detector_param: PAT_W must be 2..16 and CNT_W at least 1");
    end

    // Table is padded to a power of two so unused encodings fall back to 0.
    for (genvar s = 0; s < NTAB; s++) begin : g_tab
      localparam int FROM = (s == PAT_W) ? RESTART : s;
      localparam int RAW0 = (s <= PAT_W) ? next_prefix(PAT_EXT, PAT_W, FROM, 1'b0) : 0;
      localparam int RAW1 = (s <= PAT_W) ? next_prefix(PAT_EXT, PAT_W, FROM, 1'b1) : 0;
      localparam int NXT0 = (STYLE == OUT_MEALY && RAW0 == PAT_W) ? RESTART : RAW0;
      localparam int NXT1 = (STYLE == OUT_MEALY && RAW1 == PAT_W) ? RESTART : RAW1;
      assign nxt0_tab[s] = SW'(NXT0);
      assign nxt1_tab[s] = SW'(NXT1);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    z         = 1'b0;
    if (en) begin
      state_nxt = x ? nxt1_tab[state] : nxt0_tab[state];
    end
    if (STYLE == OUT_MOORE) begin
      z = (state == S_TERM);
    end else begin
      z = en & (state == S_LAST) & (x == PATTERN[0]);
    end
  end

`ifdef SEQ_DET_CNT_EN
  logic hit;

  // A held terminal state is not a new match; only entry counts.
  assign hit = (STYLE == OUT_MOORE) ? (en & (state_nxt == S_TERM)) : z;

  sat_counter #(
    .W   (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .q   (match_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_param
// Brief    : Self-checking bench for seq_detector_param (four configurations).
// Revision : 1.0
// ============================================================================
module tb_seq_detector_param;

  typedef struct {
    logic en;
    logic x;
    int   sa;
    int   za;
    int   sb;
    int   zb;
    int   sc;
    int   zc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic x;

  logic [2:0] st_a, st_b, st_c, st_s;
  logic       z_a, z_b, z_c, z_s;
`ifdef SEQ_DET_CNT_EN
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl [11];
  vec_t sb_q [$];

  always #5 clk = ~clk;

  // a: Moore overlap, b: Moore non-overlap, c: Mealy overlap, s: small counter
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .MOORE(1), .OVERLAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .z(z_a), .state(st_a)
`ifdef SEQ_DET_CNT_EN
    , .match_cnt(cnt_a)
`endif
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .MOORE(1), .OVERLAP(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .z(z_b), .state(st_b)
`ifdef SEQ_DET_CNT_EN
    , .match_cnt(cnt_b)
`endif
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .MOORE(0), .OVERLAP(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .en(en), .x(x), .z(z_c), .state(st_c)
`ifdef SEQ_DET_CNT_EN
    , .match_cnt(cnt_c)
`endif
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .MOORE(1), .OVERLAP(0), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .x(x), .z(z_s), .state(st_s)
`ifdef SEQ_DET_CNT_EN
    , .match_cnt(cnt_s)
`endif
  );

  function automatic vec_t mk(input logic e, input logic b, input int sa, input int za,
                              input int sb, input int zb, input int sc, input int zc);
    vec_t v;
    v.en = e; v.x = b;
    v.sa = sa; v.za = za; v.sb = sb; v.zb = zb; v.sc = sc; v.zc = zc;
    return v;
  endfunction

  task automatic check(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d", tag, fld, act, exp);
    end
  endtask

  // Drive one bit; Mealy z is checked before the edge, everything else after.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    en = v.en;
    x  = v.x;
    sb_q.push_back(v);
    #1;
    check(tag, "z_c", 32'(z_c), v.zc);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(tag, "state_a", 32'(st_a), e.sa);
    check(tag, "z_a",     32'(z_a),  e.za);
    check(tag, "state_b", 32'(st_b), e.sb);
    check(tag, "z_b",     32'(z_b),  e.zb);
    check(tag, "state_c", 32'(st_c), e.sc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    x   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1);
  end

  initial begin
    //               en  x    sa za  sb zb  sc zc
    tbl[0]  = mk(1'b1, 1'b1, 1, 0, 1, 0, 1, 0);
    tbl[1]  = mk(1'b1, 1'b0, 2, 0, 2, 0, 2, 0);
    tbl[2]  = mk(1'b1, 1'b1, 3, 0, 3, 0, 3, 0);
    tbl[3]  = mk(1'b1, 1'b1, 4, 1, 4, 1, 1, 1);
    tbl[4]  = mk(1'b1, 1'b0, 2, 0, 0, 0, 2, 0);
    tbl[5]  = mk(1'b1, 1'b1, 3, 0, 1, 0, 3, 0);
    tbl[6]  = mk(1'b1, 1'b1, 4, 1, 1, 0, 1, 1);
    tbl[7]  = mk(1'b0, 1'b1, 4, 1, 1, 0, 1, 0);
    tbl[8]  = mk(1'b1, 1'b0, 2, 0, 2, 0, 2, 0);
    tbl[9]  = mk(1'b1, 1'b1, 3, 0, 3, 0, 3, 0);
    tbl[10] = mk(1'b1, 1'b1, 4, 1, 4, 1, 1, 1);

    rst = 1'b1;
    en  = 1'b0;
    x   = 1'b0;
    @(negedge clk);
    #1;
    check("reset", "state_a", 32'(st_a), 0);
    check("reset", "z_a",     32'(z_a),  0);
    check("reset", "state_c", 32'(st_c), 0);
    check("reset", "z_c",     32'(z_c),  0);
    check("reset", "state_s", 32'(st_s), 0);
`ifdef SEQ_DET_CNT_EN
    check("reset", "cnt_a", 32'(cnt_a), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 1011011 followed by a held cycle and one more overlapping match
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i], $sformatf("table[%0d]", i));
`ifdef SEQ_DET_CNT_EN
      if (i == 6) begin
        check("table[6]", "cnt_a", 32'(cnt_a), 2);
        check("table[6]", "cnt_b", 32'(cnt_b), 1);
        check("table[6]", "cnt_c", 32'(cnt_c), 2);
      end
`endif
    end
`ifdef SEQ_DET_CNT_EN
    check("table_end", "cnt_a", 32'(cnt_a), 3);
    check("table_end", "cnt_b", 32'(cnt_b), 2);
    check("table_end", "cnt_c", 32'(cnt_c), 3);
`endif

    // asynchronous reset with three bits matched
    do_reset();
    for (int i = 0; i < 3; i++) apply(tbl[i], "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", "state_a", 32'(st_a), 0);
    check("async_rst", "z_a",     32'(z_a),  0);
    check("async_rst", "state_b", 32'(st_b), 0);
    check("async_rst", "state_c", 32'(st_c), 0);
    check("async_rst", "z_c",     32'(z_c),  0);
`ifdef SEQ_DET_CNT_EN
    check("async_rst", "cnt_a", 32'(cnt_a), 0);
    check("async_rst", "cnt_c", 32'(cnt_c), 0);
`endif
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) apply(tbl[i], "post_rst");

    // enable gap between bits 2 and 3 of 1011
    do_reset();
    apply(tbl[0], "en_gap");
    apply(tbl[1], "en_gap");
    for (int i = 0; i < 3; i++) begin
      apply(mk(1'b0, 1'($urandom_range(0, 1)), 2, 0, 2, 0, 2, 0), "en_gap_hold");
    end
    apply(tbl[2], "en_gap");
    apply(tbl[3], "en_gap");

    // five back-to-back 1011 frames against the 2-bit counter
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      for (int i = 0; i < 4; i++) apply(tbl[i], $sformatf("sat%0d", n));
      check($sformatf("sat%0d", n), "state_s", 32'(st_s), 4);
      check($sformatf("sat%0d", n), "z_s",     32'(z_s),  1);
`ifdef SEQ_DET_CNT_EN
      check($sformatf("sat%0d", n), "cnt_s", 32'(cnt_s), (n < 3) ? n : 3);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
